// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one sync single-port VRAM between VGA pixel fetch and CPU access.
// Video wins in active display, CPU wins in blanking, and a wait counter bounds how long the CPU can lose.
module vga_vram_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vid_blank,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, GNT_VID, GNT_CPU_RD, GNT_CPU_WR} state_t;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [1:0]    tv_q, tv_d, to_q, to_d;
    logic          ram_en_q, ram_en_d, ram_we_q, ram_we_d, vid_ack_q, vid_ack_d;
    logic          cpu_ready_q, cpu_ready_d, vid_rvalid_q, vid_rvalid_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d, vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d;
    logic          vid_elig, cpu_elig, cpu_win, vid_win, ret_vid, ret_cpu;

    always_comb begin
        vid_elig     = vid_req && !vid_ack_q;
        // tag pipe (valid tv, owner to: 1=cpu) tracks reads until their data returns
        cpu_elig     = cpu_req && !cpu_ready_q && !(tv_q[0] && to_q[0]) && !(tv_q[1] && to_q[1]);
        cpu_win      = cpu_elig && (!vid_elig || vid_blank || wait_q == WMAX);
        vid_win      = vid_elig && !cpu_win;
        state_d      = cpu_win ? (cpu_we ? GNT_CPU_WR : GNT_CPU_RD) : vid_win ? GNT_VID : IDLE;
        wait_d       = (!cpu_req || cpu_win) ? '0 : (cpu_elig && wait_q != WMAX) ? wait_q + 1'b1 : wait_q;
        ret_vid      = tv_q[1] && !to_q[1];
        ret_cpu      = tv_q[1] && to_q[1];
        tv_d         = {tv_q[0], vid_win || (cpu_win && !cpu_we)};
        to_d         = {to_q[0], cpu_win};
        ram_en_d     = state_d != IDLE;
        ram_we_d     = state_d == GNT_CPU_WR;
        vid_ack_d    = state_d == GNT_VID;
        cpu_ready_d  = ram_we_d || ret_cpu;
        vid_rvalid_d = ret_vid;
        ram_addr_d   = cpu_win ? cpu_addr : vid_win ? vid_addr : ram_addr_q;
        ram_wdata_d  = cpu_win ? cpu_wdata : ram_wdata_q;
        vid_rdata_d  = ret_vid ? ram_rdata : vid_rdata_q;
        cpu_rdata_d  = ret_cpu ? ram_rdata : cpu_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            tv_q         <= '0;
            to_q         <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_ready_q  <= 1'b0;
            vid_rvalid_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            vid_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            tv_q         <= tv_d;
            to_q         <= to_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            vid_ack_q    <= vid_ack_d;
            cpu_ready_q  <= cpu_ready_d;
            vid_rvalid_q <= vid_rvalid_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            vid_rdata_q  <= vid_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign vid_ack    = vid_ack_q;
    assign vid_rvalid = vid_rvalid_q;
    assign vid_rdata  = vid_rdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
endmodule
